dpram_port_master: RTL and testbench
====================================

// Module: dpram_port_master
// PURPOSE
// - Request queue and issuer sitting directly upstream of one dpram port (A or B).
// - Buffers read/write requests from a client, drives the port's valid/we/addr/data,
//   honours the port's ready, and returns read data on a response channel.
// - One instance per port; two instances drive dpram independently.
// PARAMETERS
// - DATA_WIDTH  8  width of data/q
// - ADDR_WIDTH  6  width of addr
// - DEPTH       4  request queue entries; power of 2, >=2
// - READ_LAT    1  cycles from accepted read handshake to valid q on mem_q; >=1
// PORTS
// - clk        in   1           clock, all logic on rising edge
// - rst_n      in   1           synchronous, active-low reset
// - req_valid  in   1           client request valid
// - req_ready  out  1           queue can accept a request
// - req_we     in   1           1 = write, 0 = read
// - req_addr   in   ADDR_WIDTH  request address
// - req_data   in   DATA_WIDTH  write data (ignored on reads)
// - mem_valid  out  1           to dpram valid_x
// - mem_ready  in   1           from dpram ready_x
// - mem_we     out  1           to dpram we_x
// - mem_addr   out  ADDR_WIDTH  to dpram addr_x
// - mem_data   out  DATA_WIDTH  to dpram data_x
// - mem_q      in   DATA_WIDTH  from dpram q_x
// - rsp_valid  out  1           one-cycle pulse: read data available
// - rsp_addr   out  ADDR_WIDTH  address of the returned read
// - rsp_data   out  DATA_WIDTH  read data
// - count      out  $clog2(DEPTH)+1  occupied queue entries
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): queue emptied, pipeline cleared; count=0, rsp_valid=0,
//   rsp_addr=0, rsp_data=0, mem_valid=0 (mem_we/addr/data=0 while empty). req_ready=0
//   during reset, 1 in first cycle after. Reset mid-operation discards queued requests
//   and in-flight reads; no rsp_valid for them.
// - Push: req_valid && req_ready at posedge. req_ready = (count < DEPTH); combinational
//   from registered count only, never from req_valid or mem_ready.
// - Issue: mem_valid = (count != 0); mem_we/addr/data = queue head fields.
//   Head stays stable while mem_valid && !mem_ready (AXI-style hold).
// - Pop: mem_valid && mem_ready at posedge. Strict FIFO order.
// - Push and pop in same cycle: count unchanged, both take effect; when full, req_ready
//   is 0 so no push that cycle, pop still frees an entry for the next cycle.
// - Queue pointers wrap modulo DEPTH; count saturates never (push blocked at DEPTH).
// - Read tracking: popped read enters READ_LAT-stage shift register carrying {flag,addr}.
//   At stage READ_LAT exit: rsp_valid=1 for exactly one cycle, rsp_addr=stored addr,
//   rsp_data=mem_q sampled that same cycle (registered output, i.e. rsp_* are visible
//   the cycle after q is valid). Total: rsp_valid asserted READ_LAT+1 cycles after pop.
// - Back-to-back reads popped on consecutive cycles give consecutive rsp_valid pulses.
// - Writes produce no response. No backpressure on rsp channel; client must sink.
// - Best-case throughput: one request per cycle when mem_ready held high.
// TESTING
// - Reset: hold rst_n=0 3 cycles with req_valid=1 -> count=0, mem_valid=0, rsp_valid=0.
// - Write 0xA5 @0x03 then read @0x03, mem_ready=1 -> mem sees we=1 then we=0,
//   rsp_valid pulse with rsp_addr=0x03, rsp_data=0xA5, READ_LAT+1 cycles after read pop.
// - mem_ready=0, push 5 requests (DEPTH=4) -> 4 accepted, req_ready=0, count=4,
//   mem_addr stable; release mem_ready -> 4 pops in order, 5th accepted next cycle.
// - 4 reads @0x10..0x13 streamed with mem_ready=1 -> 4 consecutive rsp_valid pulses,
//   rsp_addr 0x10..0x13 in order.
// - Full queue, push+pop same cycle attempts -> no overflow, count never exceeds 4.
// - Reset asserted one cycle after read pop -> no rsp_valid, count=0 afterwards.

Source files
------------

// File: rtl/dpram_port_master.sv
// -----------------------------------------------------------------------------
// dpram_port_master
//
// This module is a request queue and issuer that sits directly upstream of one
// dpram port. A client pushes read and write requests into a small FIFO. The
// FIFO head is presented to the memory port. Read data returns on a response
// channel after the memory read latency. Use one instance per dpram port.
//
// Handshake semantics (valid/ready, used on the req and mem channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Once valid is raised, the payload stays stable until the transfer.
//   req_ready does not depend on req_valid. mem_valid does not depend on
//   mem_ready. The rsp channel is a one-cycle pulse with no backpressure.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   req_valid/req_ready     client request handshake
//   req_we/addr/data        request payload (req_data is ignored on reads)
//   mem_valid/mem_ready     memory port handshake
//   mem_we/addr/data        memory port payload, taken from the queue head
//   mem_q                   memory read data, valid READ_LAT cycles after a
//                           read transfer
//   rsp_valid/addr/data     registered read response
//   count                   number of occupied queue entries
// -----------------------------------------------------------------------------
module dpram_port_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int READ_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  input  logic [DATA_WIDTH-1:0]     mem_q,
  output logic                      rsp_valid,
  output logic [ADDR_WIDTH-1:0]     rsp_addr,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Queue storage. These registers have no reset. The issue side masks them
  // to zero whenever the queue is empty.
  logic                  q_we   [DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic push;
  logic pop;
  logic pop_read;

  // The read tracking pipeline carries {flag, addr}. One stage is used per
  // cycle of memory latency.
  logic [READ_LAT-1:0]   pipe_vld;
  logic [ADDR_WIDTH-1:0] pipe_addr [READ_LAT];

  // req_ready comes only from the registered count. The rst_n term keeps
  // req_ready low while reset is held.
  assign req_ready = rst_n && (count < CNT_W'(DEPTH));
  assign mem_valid = (count != '0);

  assign mem_we   = mem_valid ? q_we[rd_ptr]   : 1'b0;
  assign mem_addr = mem_valid ? q_addr[rd_ptr] : '0;
  assign mem_data = mem_valid ? q_data[rd_ptr] : '0;

  assign push     = req_valid && req_ready;
  assign pop      = mem_valid && mem_ready;
  assign pop_read = pop && !mem_we;

  // Queue payload writes. No write can happen while in reset, because push
  // is gated by req_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]   <= req_we;
      q_addr[wr_ptr] <= req_addr;
      q_data[wr_ptr] <= req_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. count can never
  // exceed DEPTH, because req_ready is low when the queue is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Read response path. The last pipeline stage lines up with the cycle in
  // which mem_q is valid, so mem_q is captured into the response registers
  // at that point. Reset drops every read that is still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_addr[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      pipe_vld[0]  <= pop_read;
      pipe_addr[0] <= mem_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
      rsp_valid <= pipe_vld[READ_LAT-1];
      if (pipe_vld[READ_LAT-1]) begin
        rsp_addr <= pipe_addr[READ_LAT-1];
        rsp_data <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_dpram_port_master.sv
module tb_dpram_port_master;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int RL    = 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  dpram_port_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .count(count)
  );

  // ---------------- dpram port model ----------------
  logic [DW-1:0] mem_model [2**AW];
  logic [DW-1:0] q_pipe    [RL];

  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      if (mem_we) mem_model[mem_addr] <= mem_data;
      else        q_pipe[0]           <= mem_model[mem_addr];
    end
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RL-1];

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cnt_model = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW+DW:0]   exp_mem_q[$];   // {we, addr, data} in issue order
  logic [AW+DW-1:0] exp_rsp_q[$];   // {addr, data} for reads
  int               exp_cyc_q[$];   // cycle at which each response is due
  logic [DW-1:0]    ref_mem [2**AW];
  logic [AW-1:0]    rsp_log_addr[$];
  logic [DW-1:0]    rsp_log_data[$];
  int               rsp_log_cyc[$];

  always @(negedge clk) begin
    logic [AW+DW:0]   m;
    logic [AW+DW-1:0] r;
    int               c;
    if (!rst_n) begin
      exp_mem_q.delete();
      exp_rsp_q.delete();
      exp_cyc_q.delete();
      cnt_model = 0;
    end else begin
      chk("count", 32'(count), 32'(cnt_model));
      chk("count_le_depth", 32'(count <= DEPTH), 1);
      chk("req_ready", 32'(req_ready), 32'(cnt_model < DEPTH));
      chk("mem_valid", 32'(mem_valid), 32'(cnt_model != 0));
      if (rsp_valid) begin
        rsp_log_addr.push_back(rsp_addr);
        rsp_log_data.push_back(rsp_data);
        rsp_log_cyc.push_back(cyc);
        if (exp_rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          r = exp_rsp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("rsp_addr", 32'(rsp_addr), 32'(r[AW+DW-1:DW]));
          chk("rsp_data", 32'(rsp_data), 32'(r[DW-1:0]));
          chk("rsp_latency", cyc, c);
        end
      end
      if (req_valid && req_ready) begin
        exp_mem_q.push_back({req_we, req_addr, req_data});
        if (req_we) ref_mem[req_addr] = req_data;
        else        exp_rsp_q.push_back({req_addr, ref_mem[req_addr]});
      end
      if (mem_valid && mem_ready) begin
        if (exp_mem_q.size() == 0) begin
          chk("mem_unexpected", 1, 0);
        end else begin
          m = exp_mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m[AW+DW]));
          chk("mem_addr", 32'(mem_addr), 32'(m[AW+DW-1:DW]));
          if (m[AW+DW]) chk("mem_data", 32'(mem_data), 32'(m[DW-1:0]));
        end
        if (!mem_we) exp_cyc_q.push_back(cyc + 1 + RL);
      end
      cnt_model = cnt_model + int'(req_valid && req_ready) - int'(mem_valid && mem_ready);
    end
  end

  // ---------------- driver tasks ----------------
  // The caller is positioned just after a rising edge. The task returns just
  // after the edge that accepted the request.
  task automatic push_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("push_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (count == 0) && (exp_rsp_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [DW-1:0] wd [4];

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h05;
    req_data = 8'h77; mem_ready = 1'b1;

    // Reset: hold reset for 3 cycles with a request offered.
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_addr", 32'(rsp_addr), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_mem_payload", 32'({mem_we, mem_addr, mem_data}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 1);
    chk("post_rst_count", 32'(count), 0);
    @(posedge clk); #1;

    // Write 0xA5 to 0x03, then read it back.
    rsp_log_addr.delete(); rsp_log_data.delete(); rsp_log_cyc.delete();
    push_req(1'b1, 6'h03, 8'hA5);
    push_req(1'b0, 6'h03, 8'h00);
    wait_idle();
    chk("wr_rd_rsp_count", rsp_log_addr.size(), 1);
    if (rsp_log_addr.size() == 1) begin
      chk("wr_rd_rsp_addr", 32'(rsp_log_addr[0]), 32'h03);
      chk("wr_rd_rsp_data", 32'(rsp_log_data[0]), 32'hA5);
    end

    // Hold mem_ready low and offer 5 requests.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wd[i] = DW'($urandom_range(0, 255));
      push_req(1'b1, AW'(6'h20 + i), wd[i]);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h20; req_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_req_ready", 32'(req_ready), 0);
      chk("full_count", 32'(count), 4);
      chk("hold_mem_addr", 32'(mem_addr), 32'h20);
      chk("hold_mem_we", 32'(mem_we), 1);
      chk("hold_mem_data", 32'(mem_data), 32'(wd[0]));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready_0", 32'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_req_ready_1", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    // Stream 4 reads from 0x10..0x13 with mem_ready held high.
    for (int i = 0; i < 4; i++) push_req(1'b1, AW'(6'h10 + i), DW'($urandom_range(0, 255)));
    wait_idle();
    rsp_log_addr.delete(); rsp_log_data.delete(); rsp_log_cyc.delete();
    for (int i = 0; i < 4; i++) push_req(1'b0, AW'(6'h10 + i), 8'h00);
    wait_idle();
    chk("stream_rsp_count", rsp_log_addr.size(), 4);
    if (rsp_log_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("stream_rsp_addr", 32'(rsp_log_addr[k]), 32'h10 + k);
      for (int k = 1; k < 4; k++) chk("stream_consecutive", rsp_log_cyc[k] - rsp_log_cyc[k-1], 1);
    end

    // Full queue, with push and pop attempted in the same cycle.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req(1'b1, AW'(6'h30 + i), DW'($urandom_range(0, 255)));
    for (int i = 0; i < 24; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_data = 8'h00;
      req_addr  = AW'(6'h30 + $urandom_range(0, 3));
      mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'b1;
    wait_idle();

    // Assert reset one cycle after a read is popped.
    rsp_log_addr.delete(); rsp_log_data.delete(); rsp_log_cyc.delete();
    push_req(1'b0, 6'h10, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_mid_rst_rsp_valid", 32'(rsp_valid), 0);
    end
    chk("post_mid_rst_count", 32'(count), 0);
    chk("post_mid_rst_no_rsp", rsp_log_addr.size(), 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
